// File: rtl/reset_sequencer.sv
// Staged reset release: RAM controller first, gated on its init-done
// handshake with timeout and bounded retries, then the core logic.
module reset_sequencer #(
    parameter int HOLD_CYCLES = 16,
    parameter int RAM_TIMEOUT = 65535,
    parameter int CORE_DELAY  = 8,
    parameter int RETRIES     = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       softRstReq,
    input  logic       ramInitDone,
    output logic       ramRst,
    output logic       coreRst,
    output logic       ready,
    output logic       err,
    output logic [3:0] retryCount
);

    localparam int MAX_HR  = (HOLD_CYCLES > RAM_TIMEOUT) ? HOLD_CYCLES : RAM_TIMEOUT;
    localparam int MAX_CNT = (MAX_HR > CORE_DELAY) ? MAX_HR : CORE_DELAY;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(RAM_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CD_LAST   = CNT_W'(CORE_DELAY - 1);
    localparam logic [3:0]       RETRY_MAX = 4'(RETRIES);

    typedef enum logic [2:0] {
        S_HOLD,
        S_RAM_INIT,
        S_CORE_DELAY,
        S_RUN,
        S_FAIL
    } state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [3:0]       retry_n;
    logic             ram_rst_n, core_rst_n, ready_n, err_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_HOLD;
            cnt        <= '0;
            retryCount <= 4'd0;
            ramRst     <= 1'b1;
            coreRst    <= 1'b1;
            ready      <= 1'b0;
            err        <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            retryCount <= retry_n;
            ramRst     <= ram_rst_n;
            coreRst    <= core_rst_n;
            ready      <= ready_n;
            err        <= err_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt + 1'b1;
        retry_n = retryCount;
        if (softRstReq) begin
            state_n = S_HOLD;
            retry_n = 4'd0;
        end else begin
            unique case (state)
                S_HOLD: begin
                    if (cnt == HOLD_LAST)
                        state_n = S_RAM_INIT;
                end
                S_RAM_INIT: begin
                    if (ramInitDone) begin
                        state_n = S_CORE_DELAY;
                    end else if (cnt == TO_LAST) begin
                        if (retryCount < RETRY_MAX) begin
                            retry_n = retryCount + 4'd1;
                            state_n = S_HOLD;
                        end else begin
                            state_n = S_FAIL;
                        end
                    end
                end
                S_CORE_DELAY: begin
                    if (cnt == CD_LAST)
                        state_n = S_RUN;
                end
                S_RUN:   cnt_n = '0;
                S_FAIL:  cnt_n = '0;
                default: state_n = S_HOLD;
            endcase
        end
        // Any transition (including a held restart request) restarts the count
        if (softRstReq || state_n != state)
            cnt_n = '0;

        ram_rst_n  = !(state_n == S_RAM_INIT || state_n == S_CORE_DELAY
                       || state_n == S_RUN);
        core_rst_n = (state_n != S_RUN);
        ready_n    = (state_n == S_RUN);
        err_n      = (state_n == S_FAIL);
    end

endmodule
